// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one outstanding request, redirect flush, misaligned-PC trap
// Feeds a registered if_id slot that holds while decode stalls.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid_o,
  output logic [63:0] ireq_addr_o,
  input  logic        iresp_data_ok_i,
  input  logic [31:0] iresp_data_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_inst_o,
  output logic [63:0] if_id_inst_pc_o,
  output logic [63:0] if_id_inst_counter_o,
  output logic        if_id_trap_valid_o,
  output logic [63:0] if_id_trap_code_o,
  output logic        if_id_is_exception_o
);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH, HALT} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] req_addr_q;
  logic [63:0] count_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic [63:0] out_pc_q;
  logic [63:0] out_count_q;
  logic        out_trap_valid_q;
  logic [63:0] out_trap_code_q;
  logic        out_is_exc_q;
  logic        slot_free_d;

  assign slot_free_d = !out_valid_q || !stall_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      pc_q             <= RESET_PC;
      req_addr_q       <= 64'd0;
      count_q          <= 64'd0;
      out_valid_q      <= 1'b0;
      out_inst_q       <= 32'd0;
      out_pc_q         <= 64'd0;
      out_count_q      <= 64'd0;
      out_trap_valid_q <= 1'b0;
      out_trap_code_q  <= 64'd0;
      out_is_exc_q     <= 1'b0;
    end else if (redirect_valid_i) begin
      // Redirect beats stall and data_ok; a response landing this cycle is dropped.
      pc_q        <= redirect_pc_i;
      out_valid_q <= 1'b0;
      case (state_q)
        BUSY, FLUSH: state_q <= iresp_data_ok_i ? IDLE : FLUSH;
        default:     state_q <= IDLE;
      endcase
    end else begin
      if (!stall_i) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (slot_free_d) begin
            if (pc_q[1:0] == 2'b00) begin
              req_addr_q <= pc_q;
              state_q    <= BUSY;
            end else begin
              out_valid_q      <= 1'b1;
              out_inst_q       <= 32'd0;
              out_pc_q         <= pc_q;
              out_count_q      <= count_q;
              out_trap_valid_q <= 1'b1;
              out_trap_code_q  <= 64'd0;
              out_is_exc_q     <= 1'b1;
              count_q          <= count_q + 64'd1;
              state_q          <= HALT;
            end
          end
        end
        BUSY: begin
          if (iresp_data_ok_i) begin
            out_valid_q      <= 1'b1;
            out_inst_q       <= iresp_data_i;
            out_pc_q         <= req_addr_q;
            out_count_q      <= count_q;
            out_trap_valid_q <= 1'b0;
            out_trap_code_q  <= 64'd0;
            out_is_exc_q     <= 1'b0;
            count_q          <= count_q + 64'd1;
            pc_q             <= req_addr_q + 64'd4;
            state_q          <= IDLE;
          end
        end
        FLUSH: begin
          if (iresp_data_ok_i) state_q <= IDLE;
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign ireq_valid_o         = (state_q == BUSY) || (state_q == FLUSH);
  assign ireq_addr_o          = req_addr_q;
  assign if_id_valid_o        = out_valid_q;
  assign if_id_inst_o         = out_inst_q;
  assign if_id_inst_pc_o      = out_pc_q;
  assign if_id_inst_counter_o = out_count_q;
  assign if_id_trap_valid_o   = out_trap_valid_q;
  assign if_id_trap_code_o    = out_trap_code_q;
  assign if_id_is_exception_o = out_is_exc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        data_ok = 1'b0;
  logic [31:0] data = 32'd0;
  logic        stall = 1'b0;
  logic        rdv = 1'b0;
  logic [63:0] rpc = 64'd0;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [63:0] o_pc;
  logic [63:0] o_cnt;
  logic        o_tv;
  logic [63:0] o_tc;
  logic        o_exc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(B)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid_o(ireq_valid), .ireq_addr_o(ireq_addr),
    .iresp_data_ok_i(data_ok), .iresp_data_i(data),
    .stall_i(stall), .redirect_valid_i(rdv), .redirect_pc_i(rpc),
    .if_id_valid_o(o_valid), .if_id_inst_o(o_inst), .if_id_inst_pc_o(o_pc),
    .if_id_inst_counter_o(o_cnt), .if_id_trap_valid_o(o_tv),
    .if_id_trap_code_o(o_tc), .if_id_is_exception_o(o_exc)
  );

  typedef struct {
    logic        rst, stl, dok;
    logic [31:0] dat;
    logic        rdv;
    logic [63:0] rpc;
    logic        chk, full, e_rv;
    logic [63:0] e_ra;
    logic        e_v;
    logic [31:0] e_inst;
    logic [63:0] e_pc, e_cnt;
    logic        e_trap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, stl, dok, input logic [31:0] dat, input logic rd,
                     input logic [63:0] rp, input logic chk, full, e_rv, input logic [63:0] e_ra,
                     input logic e_v, input logic [31:0] e_inst, input logic [63:0] e_pc, e_cnt,
                     input logic e_trap);
    vec_t v;
    v.rst = rst; v.stl = stl; v.dok = dok; v.dat = dat; v.rdv = rd; v.rpc = rp;
    v.chk = chk; v.full = full; v.e_rv = e_rv; v.e_ra = e_ra; v.e_v = e_v;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_trap = e_trap;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, stl, dok, input logic [31:0] dat, input logic rd,
                       input logic [63:0] rp);
    reset = rst; stall = stl; data_ok = dok; data = dat; rdv = rd; rpc = rp;
  endtask

  initial begin
    //   rst stl dok data          rdv rpc        chk full rv addr     v inst          pc         cnt trap
    add(1, 0, 0, 32'h0,          0, 64'h0,      0, 0, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(1, 0, 0, 32'h0,          0, 64'h0,      1, 1, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 1, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 1, 32'h0000_00A0,  0, 64'h0,      1, 0, 1, B,       0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   1, 32'h0000_00A0, B,        0, 0);
    add(0, 0, 1, 32'h0000_00A1,  0, 64'h0,      1, 0, 1, B+4,     0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   1, 32'h0000_00A1, B+4,      1, 0);
    add(0, 0, 1, 32'h0000_00A2,  0, 64'h0,      1, 0, 1, B+8,     0, 32'h0,        64'h0,     0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 32'h0,        0, 64'h0,      1, 0, 0, 64'h0,   1, 32'h0000_00A2, B+8,      2, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   1, 32'h0000_00A2, B+8,      2, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 1, B+12,    0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          1, B+64'h100,  1, 0, 1, B+12,    0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 1, B+12,    0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 1, B+12,    0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 1, 32'hDEAD_DEAD,  0, 64'h0,      1, 0, 1, B+12,    0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 1, 32'hBEEF_BEEF,  1, B+64'h200,  1, 0, 1, B+64'h100, 0, 32'h0,      64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 1, 32'h0000_00B0,  0, 64'h0,      1, 0, 1, B+64'h200, 0, 32'h0,      64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          1, B+64'h102,  1, 0, 0, 64'h0,   1, 32'h0000_00B0, B+64'h200, 3, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   1, 32'h0,        B+64'h102, 4, 1);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          1, B+64'h200,  1, 0, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(1, 0, 0, 32'h0,          0, 64'h0,      1, 0, 1, B+64'h200, 0, 32'h0,      64'h0,     0, 0);
    add(0, 0, 1, 32'h1111_1111,  0, 64'h0,      1, 1, 0, 64'h0,   0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 1, 32'h0000_00C0,  0, 64'h0,      1, 0, 1, B,       0, 32'h0,        64'h0,     0, 0);
    add(0, 0, 0, 32'h0,          0, 64'h0,      1, 0, 0, 64'h0,   1, 32'h0000_00C0, B,        0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d ireq_valid", i), {63'd0, ireq_valid}, {63'd0, vecs[i].e_rv});
        if (vecs[i].e_rv || vecs[i].full)
          chk($sformatf("v%0d ireq_addr", i), ireq_addr, vecs[i].e_ra);
        chk($sformatf("v%0d valid", i), {63'd0, o_valid}, {63'd0, vecs[i].e_v});
        if (vecs[i].e_v || vecs[i].full) begin
          chk($sformatf("v%0d inst", i), {32'd0, o_inst}, {32'd0, vecs[i].e_inst});
          chk($sformatf("v%0d inst_pc", i), o_pc, vecs[i].e_pc);
          chk($sformatf("v%0d counter", i), o_cnt, vecs[i].e_cnt);
          chk($sformatf("v%0d trap_valid", i), {63'd0, o_tv}, {63'd0, vecs[i].e_trap});
          chk($sformatf("v%0d trap_code", i), o_tc, 64'd0);
          chk($sformatf("v%0d is_exc", i), {63'd0, o_exc}, {63'd0, vecs[i].e_trap});
        end
      end
      drive(vecs[i].rst, vecs[i].stl, vecs[i].dok, vecs[i].dat, vecs[i].rdv, vecs[i].rpc);
    end

    // Back-to-back redirects in FLUSH (last wins), then a fetch that wraps pc to zero.
    @(negedge clk);
    chk("flush req", {63'd0, ireq_valid}, 64'd1);
    chk("flush addr", ireq_addr, B + 4);
    drive(0, 0, 0, 32'h0, 1, B + 64'h300);
    @(negedge clk);
    chk("flush hold", {63'd0, ireq_valid}, 64'd1);
    drive(0, 0, 0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    chk("flush still", {63'd0, ireq_valid}, 64'd1);
    drive(0, 0, 1, 32'h7777_7777, 0, 64'h0);
    @(negedge clk);
    chk("flush done", {63'd0, ireq_valid}, 64'd0);
    chk("flush no out", {63'd0, o_valid}, 64'd0);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    @(negedge clk);
    chk("last redirect addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("last redirect req", {63'd0, ireq_valid}, 64'd1);
    drive(0, 0, 1, 32'h0000_0055, 0, 64'h0);
    @(negedge clk);
    chk("wrap inst", {32'd0, o_inst}, 64'h55);
    chk("wrap pc", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap counter", o_cnt, 64'd1);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    @(negedge clk);
    chk("wrap next req", {63'd0, ireq_valid}, 64'd1);
    chk("wrap next addr", ireq_addr, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ireq.valid  output  1  instruction fetch request valid.
REQ-006 ireq.addr  output  64  fetch address.
REQ-007 iresp.data_ok  input  1  fetch response valid; completes the outstanding request.
REQ-008 iresp.data  input  32  fetched instruction.
REQ-009 stall  input  1  decode stage cannot accept; hold if_id_state.
REQ-010 redirect_valid  input  1  branch/trap redirect pulse.
REQ-011 redirect_pc  input  64  redirect target.
REQ-012 if_id_state  output  if_id  fields valid(1), inst(32), inst_pc(64), inst_counter(64), trap{trap_valid(1), trap_code(64), is_exception(1)}; all registered.

Function
REQ-013 States: IDLE (may issue), BUSY (request outstanding), FLUSH (outstanding request to discard), HALT (misaligned trap emitted, waiting for redirect).
REQ-014 ireq.valid = 1 exactly in BUSY and FLUSH; ireq.addr = registered request address, stable until data_ok.
REQ-015 Output slot free = !if_id_state.valid || !stall.
REQ-016 IDLE, slot free, pc[1:0]==0, no redirect: latch req_addr=pc; next state BUSY.
REQ-017 IDLE, slot free, pc[1:0]!=0, no redirect: load output valid=1, inst=0, inst_pc=pc, trap_valid=1, trap_code=0, is_exception=1; no request; next state HALT.
REQ-018 IDLE, slot not free: hold state, no request.
REQ-019 BUSY, data_ok, no redirect: load output valid=1, inst=iresp.data, inst_pc=req_addr, trap all zero; pc <= req_addr+4 (64-bit wrap); next IDLE.
REQ-020 BUSY, no data_ok: stay BUSY.
REQ-021 FLUSH: stay until data_ok; data discarded; then IDLE.
REQ-022 HALT: stays until redirect; never issues requests.
REQ-023 Output drain: if_id_state.valid cleared next cycle when stall=0 and nothing loaded; held bit-exact while stall=1.
REQ-024 inst_counter: 64-bit internal count, reset 0; each output load takes current count, count increments by 1 (includes trap entries).
REQ-025 Redirect (highest priority, over stall and data_ok): pc <= redirect_pc; output valid <= 0; IDLE/HALT -> IDLE; BUSY without data_ok -> FLUSH; BUSY with same-cycle data_ok -> IDLE, data dropped, counter unchanged; FLUSH -> FLUSH, or IDLE if same-cycle data_ok.
REQ-026 Redirect during FLUSH overwrites pc; last redirect wins.
REQ-027 Throughput: at most one instruction per two cycles plus memory latency; data_ok in cycle N -> if_id_state.valid in N+1.

Reset
REQ-028 reset: state IDLE, pc=RESET_PC, counter=0, ireq.valid=0, if_id_state all fields 0; overrides every other input.
REQ-029 reset mid-BUSY/FLUSH: request abandoned; a data_ok arriving after reset deasserts while IDLE is ignored.
REQ-030 First cycle after reset: IDLE; cycle 2: ireq.valid=1, ireq.addr=RESET_PC.

Verification
REQ-031 Reset, data_ok=1 same cycle as each request, stall=0 -> outputs inst_pc 8000_0000, 8000_0004, 8000_0008, inst_counter 0,1,2.
REQ-032 Output valid, stall=1 for 5 cycles -> if_id_state unchanged, ireq.valid=0 throughout; stall=0 -> next request issued following cycle.
REQ-033 BUSY, redirect_pc=8000_0100, data_ok 3 cycles later -> data dropped, then request addr 8000_0100, no output in between.
REQ-034 redirect and data_ok same cycle in BUSY -> no output, next request addr = redirect_pc, counter unchanged.
REQ-035 redirect_pc=8000_0102 -> no request; output trap_valid=1, trap_code=0, inst_pc=8000_0102; HALT until redirect 8000_0200 -> request 8000_0200.
REQ-036 reset asserted in BUSY -> next cycle ireq.valid=0, if_id_state.valid=0, pc=RESET_PC.
